// File: rtl/mem_port_arbiter.sv
// Shares one OBI-style memory port between the fetch and load/store requesters.
// An in-order ID FIFO steers each memory response back to the requester that issued it.
module mem_port_arbiter #(
    parameter int WORD_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2,
    parameter int DATA_PRIORITY   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  instr_req_i,
    input  logic [WORD_WIDTH-1:0] instr_addr_i,
    output logic                  instr_gnt_o,
    output logic                  instr_rvalid_o,
    output logic [WORD_WIDTH-1:0] instr_rdata_o,
    input  logic                  data_req_i,
    input  logic [WORD_WIDTH-1:0] data_addr_i,
    input  logic                  data_we_i,
    input  logic [3:0]            data_be_i,
    input  logic [WORD_WIDTH-1:0] data_wdata_i,
    output logic                  data_gnt_o,
    output logic                  data_rvalid_o,
    output logic [WORD_WIDTH-1:0] data_rdata_o,
    output logic                  mem_req_o,
    output logic [WORD_WIDTH-1:0] mem_addr_o,
    output logic                  mem_we_o,
    output logic [3:0]            mem_be_o,
    output logic [WORD_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [WORD_WIDTH-1:0] mem_rdata_i,
    output logic                  err_o,
    output logic [1:0]            arb_state
);

    // Handshake: a request is accepted on any cycle where mem_req_o and mem_gnt_i
    // are both high; the matching x_gnt_o pulses in that same cycle, and the
    // requester must hold req and its payload stable until then.

    typedef enum logic [1:0] {
        FREE     = 2'd0,
        LOCKED_I = 2'd1,
        LOCKED_D = 2'd2
    } arb_state_e;

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    arb_state_e                 state_q, state_d;
    logic                       last_data_q;
    logic [MAX_OUTSTANDING-1:0] id_q, id_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d, cnt_base;
    logic                       err_q;
    logic                       fifo_full, fifo_empty;
    logic                       sel_data, req_any, issue, pop;

    always_comb begin
        fifo_full  = (cnt_q == CNT_W'(MAX_OUTSTANDING));
        fifo_empty = (cnt_q == '0);
        sel_data   = 1'b0;
        req_any    = 1'b0;
        case (state_q)
            LOCKED_I: req_any = 1'b1;
            LOCKED_D: begin
                req_any  = 1'b1;
                sel_data = 1'b1;
            end
            default: begin
                req_any = instr_req_i | data_req_i;
                // On a tie in round-robin mode, whoever was not granted last wins.
                if (instr_req_i && data_req_i)
                    sel_data = (DATA_PRIORITY != 0) ? 1'b1 : ~last_data_q;
                else
                    sel_data = data_req_i;
            end
        endcase
        mem_req_o = rst_n & req_any & ~fifo_full;
        issue     = mem_req_o & mem_gnt_i;
        pop       = mem_rvalid_i & ~fifo_empty;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FREE: begin
                if (mem_req_o && !mem_gnt_i)
                    state_d = sel_data ? LOCKED_D : LOCKED_I;
            end
            LOCKED_I, LOCKED_D: begin
                if (issue)
                    state_d = FREE;
            end
            default: state_d = FREE;
        endcase
    end

    // Head of the ID FIFO is always bit 0; a pop shifts the queue down.
    always_comb begin
        id_d     = pop ? (id_q >> 1) : id_q;
        cnt_base = pop ? (cnt_q - CNT_W'(1)) : cnt_q;
        cnt_d    = issue ? (cnt_base + CNT_W'(1)) : cnt_base;
        for (int k = 0; k < MAX_OUTSTANDING; k++) begin
            if (issue && (cnt_base == CNT_W'(k)))
                id_d[k] = sel_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FREE;
            last_data_q <= 1'b1;
            id_q        <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
            if (issue)
                last_data_q <= sel_data;
            if (mem_rvalid_i && fifo_empty)
                err_q <= 1'b1;
        end
    end

    always_comb begin
        instr_gnt_o    = issue & ~sel_data;
        data_gnt_o     = issue & sel_data;
        instr_rvalid_o = rst_n & pop & ~id_q[0];
        data_rvalid_o  = rst_n & pop & id_q[0];
        instr_rdata_o  = rst_n ? mem_rdata_i : '0;
        data_rdata_o   = rst_n ? mem_rdata_i : '0;
        mem_addr_o     = '0;
        mem_we_o       = 1'b0;
        mem_be_o       = 4'h0;
        mem_wdata_o    = '0;
        if (rst_n) begin
            if (sel_data) begin
                mem_addr_o  = data_addr_i;
                mem_we_o    = data_we_i;
                mem_be_o    = data_be_i;
                mem_wdata_o = data_wdata_i;
            end else begin
                mem_addr_o = instr_addr_i;
                mem_be_o   = 4'hF;
            end
        end
        err_o     = err_q;
        arb_state = state_q;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: instance 0 runs round-robin, instance 1 data-priority.
// A transaction-level model (pending queue, lock owner, last winner) predicts every output.
module tb_mem_port_arbiter;

    localparam int W    = 32;
    localparam int MAXO = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         instr_req [2];
    logic [W-1:0] instr_addr [2];
    logic         instr_gnt [2];
    logic         instr_rvalid [2];
    logic [W-1:0] instr_rdata [2];
    logic         data_req [2];
    logic [W-1:0] data_addr [2];
    logic         data_we [2];
    logic [3:0]   data_be [2];
    logic [W-1:0] data_wdata [2];
    logic         data_gnt [2];
    logic         data_rvalid [2];
    logic [W-1:0] data_rdata [2];
    logic         mem_req [2];
    logic [W-1:0] mem_addr [2];
    logic         mem_we [2];
    logic [3:0]   mem_be [2];
    logic [W-1:0] mem_wdata [2];
    logic         mem_gnt [2];
    logic         mem_rvalid [2];
    logic [W-1:0] mem_rdata [2];
    logic         err [2];
    logic [1:0]   arb_state [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_port_arbiter #(
            .WORD_WIDTH(W),
            .MAX_OUTSTANDING(MAXO),
            .DATA_PRIORITY(g)
        ) u_dut (
            .clk(clk),
            .rst_n(rst_n),
            .instr_req_i(instr_req[g]),
            .instr_addr_i(instr_addr[g]),
            .instr_gnt_o(instr_gnt[g]),
            .instr_rvalid_o(instr_rvalid[g]),
            .instr_rdata_o(instr_rdata[g]),
            .data_req_i(data_req[g]),
            .data_addr_i(data_addr[g]),
            .data_we_i(data_we[g]),
            .data_be_i(data_be[g]),
            .data_wdata_i(data_wdata[g]),
            .data_gnt_o(data_gnt[g]),
            .data_rvalid_o(data_rvalid[g]),
            .data_rdata_o(data_rdata[g]),
            .mem_req_o(mem_req[g]),
            .mem_addr_o(mem_addr[g]),
            .mem_we_o(mem_we[g]),
            .mem_be_o(mem_be[g]),
            .mem_wdata_o(mem_wdata[g]),
            .mem_gnt_i(mem_gnt[g]),
            .mem_rvalid_i(mem_rvalid[g]),
            .mem_rdata_i(mem_rdata[g]),
            .err_o(err[g]),
            .arb_state(arb_state[g])
        );
    end

    int         checks   = 0;
    int         failures = 0;
    int         cur      = 1;
    logic [0:0] exp_q[$];
    int         m_lock;
    bit         m_last;
    bit         m_err;
    bit         e_igrant, e_dgrant;

    task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s (inst %0d): got %0h expected %0h", tag, cur, obs, exp);
        end
    endtask

    task automatic idle_all();
        for (int k = 0; k < 2; k++) begin
            instr_req[k]  = 1'b0;
            instr_addr[k] = '0;
            data_req[k]   = 1'b0;
            data_addr[k]  = '0;
            data_we[k]    = 1'b0;
            data_be[k]    = 4'h0;
            data_wdata[k] = '0;
            mem_gnt[k]    = 1'b0;
            mem_rvalid[k] = 1'b0;
            mem_rdata[k]  = '0;
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_lock = -1;
        m_last = 1'b1;
        m_err  = 1'b0;
    endtask

    // Predict this cycle's outputs from the current inputs, compare, then retire the cycle.
    task automatic model_check();
        int  win;
        bit  e_req, rv;
        logic [0:0] head;
        win = -1;
        if (exp_q.size() < MAXO) begin
            if (m_lock >= 0)                          win = m_lock;
            else if (instr_req[cur] && data_req[cur]) win = (cur == 1) ? 1 : (m_last ? 0 : 1);
            else if (data_req[cur])                   win = 1;
            else if (instr_req[cur])                  win = 0;
        end
        e_req    = (win >= 0);
        e_igrant = e_req && mem_gnt[cur] && (win == 0);
        e_dgrant = e_req && mem_gnt[cur] && (win == 1);
        check_eq("mem_req", W'(mem_req[cur]), W'(e_req));
        check_eq("instr_gnt", W'(instr_gnt[cur]), W'(e_igrant));
        check_eq("data_gnt", W'(data_gnt[cur]), W'(e_dgrant));
        if (win == 1) begin
            check_eq("addr_d", mem_addr[cur], data_addr[cur]);
            check_eq("we_d", W'(mem_we[cur]), W'(data_we[cur]));
            check_eq("be_d", W'(mem_be[cur]), W'(data_be[cur]));
            check_eq("wdata_d", mem_wdata[cur], data_wdata[cur]);
        end else if (win == 0) begin
            check_eq("addr_i", mem_addr[cur], instr_addr[cur]);
            check_eq("we_i", W'(mem_we[cur]), 32'h0);
            check_eq("be_i", W'(mem_be[cur]), 32'hF);
            check_eq("wdata_i", mem_wdata[cur], 32'h0);
        end
        rv   = mem_rvalid[cur] && (exp_q.size() > 0);
        head = (exp_q.size() > 0) ? exp_q[0] : 1'b0;
        check_eq("instr_rvalid", W'(instr_rvalid[cur]), W'(rv && head == 1'b0));
        check_eq("data_rvalid", W'(data_rvalid[cur]), W'(rv && head == 1'b1));
        check_eq("instr_rdata", instr_rdata[cur], mem_rdata[cur]);
        check_eq("data_rdata", data_rdata[cur], mem_rdata[cur]);
        check_eq("err", W'(err[cur]), W'(m_err));
        if (mem_rvalid[cur]) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            else                  m_err = 1'b1;
        end
        if (e_igrant || e_dgrant) begin
            exp_q.push_back(e_dgrant ? 1'b1 : 1'b0);
            m_last = e_dgrant;
            m_lock = -1;
        end else if (e_req) begin
            m_lock = win;
        end
    endtask

    task automatic sample();
        @(negedge clk);
        model_check();
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        sample();
        advance();
    endtask

    task automatic do_reset();
        idle_all();
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("rst_mem_req", W'(mem_req[cur]), 32'h0);
        check_eq("rst_err", W'(err[cur]), 32'h0);
        check_eq("rst_addr", mem_addr[cur], 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic drain();
        instr_req[cur] = 1'b0;
        data_req[cur]  = 1'b0;
        mem_gnt[cur]   = 1'b0;
        for (int k = 0; k < 8 && exp_q.size() > 0; k++) begin
            mem_rvalid[cur] = 1'b1;
            mem_rdata[cur]  = $urandom;
            step();
        end
        mem_rvalid[cur] = 1'b0;
        check_eq("drained", W'(exp_q.size()), 32'h0);
    endtask

    task automatic run_random(input int n);
        bit ipend = 1'b0;
        bit dpend = 1'b0;
        for (int c = 0; c < n; c++) begin
            if (!ipend && $urandom_range(0, 1) == 1) begin
                ipend = 1'b1;
                instr_addr[cur] = $urandom;
            end
            if (!dpend && $urandom_range(0, 1) == 1) begin
                dpend = 1'b1;
                data_addr[cur]  = $urandom;
                data_we[cur]    = 1'($urandom_range(0, 1));
                data_be[cur]    = 4'($urandom_range(0, 15));
                data_wdata[cur] = $urandom;
            end
            instr_req[cur]  = ipend;
            data_req[cur]   = dpend;
            mem_gnt[cur]    = ($urandom_range(0, 9) < 7);
            mem_rvalid[cur] = (exp_q.size() > 0) && ($urandom_range(0, 1) == 1);
            mem_rdata[cur]  = $urandom;
            sample();
            if (e_igrant) ipend = 1'b0;
            if (e_dgrant) dpend = 1'b0;
            advance();
        end
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        idle_all();
        rst_n = 1'b0;
        model_reset();

        // Instr-only transaction with single-cycle grant and response.
        cur = 1;
        do_reset();
        instr_req[1] = 1'b1; instr_addr[1] = 32'h100; mem_gnt[1] = 1'b1;
        sample();
        check_eq("t1_gnt", W'(instr_gnt[1]), 32'h1);
        check_eq("t1_addr", mem_addr[1], 32'h100);
        advance();
        instr_req[1] = 1'b0; mem_gnt[1] = 1'b0; mem_rvalid[1] = 1'b1; mem_rdata[1] = 32'hDEADBEEF;
        sample();
        check_eq("t1_rvalid", W'(instr_rvalid[1]), 32'h1);
        check_eq("t1_rdata", instr_rdata[1], 32'hDEADBEEF);
        check_eq("t1_drvalid", W'(data_rvalid[1]), 32'h0);
        advance();

        // Simultaneous requests with data priority.
        do_reset();
        instr_req[1] = 1'b1; instr_addr[1] = 32'h200;
        data_req[1] = 1'b1; data_addr[1] = 32'h300; data_be[1] = 4'h3; data_we[1] = 1'b1;
        data_wdata[1] = 32'hCAFE0001; mem_gnt[1] = 1'b1;
        sample();
        check_eq("t2_first", mem_addr[1], 32'h300);
        advance();
        data_req[1] = 1'b0; mem_rvalid[1] = 1'b1; mem_rdata[1] = 32'h11111111;
        sample();
        check_eq("t2_second", mem_addr[1], 32'h200);
        check_eq("t2_dresp", W'(data_rvalid[1]), 32'h1);
        advance();
        instr_req[1] = 1'b0; mem_rdata[1] = 32'h22222222;
        sample();
        check_eq("t2_iresp", W'(instr_rvalid[1]), 32'h1);
        advance();
        idle_all();

        // Round-robin alternation.
        cur = 0;
        do_reset();
        instr_req[0] = 1'b1; instr_addr[0] = 32'h400;
        data_req[0] = 1'b1; data_addr[0] = 32'h500; mem_gnt[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mem_rvalid[0] = (i > 0);
            sample();
            check_eq("t3_rr_order", W'(instr_gnt[0]), W'(i % 2 == 0));
            advance();
        end
        drain();

        // Lock held while memory stalls the grant.
        cur = 1;
        do_reset();
        data_req[1] = 1'b1; data_addr[1] = 32'h300;
        for (int i = 0; i < 3; i++) begin
            if (i >= 1) begin
                instr_req[1] = 1'b1; instr_addr[1] = 32'h200;
            end
            sample();
            check_eq("t4_lock_addr", mem_addr[1], 32'h300);
            check_eq("t4_no_igrant", W'(instr_gnt[1]), 32'h0);
            advance();
        end
        mem_gnt[1] = 1'b1;
        sample();
        check_eq("t4_dgrant", W'(data_gnt[1]), 32'h1);
        advance();
        data_req[1] = 1'b0;
        sample();
        check_eq("t4_igrant", W'(instr_gnt[1]), 32'h1);
        advance();
        drain();

        // Full FIFO stalls issue, even on the popping cycle.
        do_reset();
        instr_req[1] = 1'b1; instr_addr[1] = 32'h600; mem_gnt[1] = 1'b1;
        step();
        step();
        sample();
        check_eq("t5_stall", W'(mem_req[1]), 32'h0);
        advance();
        mem_rvalid[1] = 1'b1; mem_rdata[1] = 32'h5555AAAA;
        sample();
        check_eq("t5_stall_pop", W'(mem_req[1]), 32'h0);
        advance();
        mem_rvalid[1] = 1'b0;
        sample();
        check_eq("t5_resume", W'(mem_req[1]), 32'h1);
        advance();
        drain();

        // Stray response, then a mid-stream reset that discards outstanding IDs.
        do_reset();
        mem_rvalid[1] = 1'b1; mem_rdata[1] = 32'h77;
        sample();
        check_eq("t6_no_rvalid", W'(instr_rvalid[1] | data_rvalid[1]), 32'h0);
        advance();
        mem_rvalid[1] = 1'b0;
        sample();
        check_eq("t6_err_set", W'(err[1]), 32'h1);
        advance();
        instr_req[1] = 1'b1; instr_addr[1] = 32'h700; mem_gnt[1] = 1'b1;
        step();
        mem_gnt[1] = 1'b0; mem_rvalid[1] = 1'b1; mem_rdata[1] = 32'h33;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_req", W'(mem_req[1]), 32'h0);
        check_eq("t6_rst_err", W'(err[1]), 32'h0);
        check_eq("t6_rst_addr", mem_addr[1], 32'h0);
        check_eq("t6_rst_be", W'(mem_be[1]), 32'h0);
        check_eq("t6_rst_rdata", instr_rdata[1], 32'h0);
        check_eq("t6_rst_rvalid", W'(instr_rvalid[1] | data_rvalid[1]), 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        instr_req[1] = 1'b0;
        step();
        mem_rvalid[1] = 1'b0;
        sample();
        check_eq("t6_err_again", W'(err[1]), 32'h1);
        advance();

        // Randomized traffic on both arbitration modes.
        for (int m = 1; m >= 0; m--) begin
            cur = m;
            do_reset();
            run_random(400);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
